// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, fetch FSM states and the opcode map.
// The decode ROM and the fetch unit both import this package.
package cpu_pkg;

  localparam int INST_W     = 16;
  localparam int OPCODE_W   = 4;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2
  } fetch_state_t;

  localparam logic [OPCODE_W-1:0] ADD  = 4'h0;
  localparam logic [OPCODE_W-1:0] SUB  = 4'h1;
  localparam logic [OPCODE_W-1:0] LAND = 4'h2;
  localparam logic [OPCODE_W-1:0] LOR  = 4'h3;
  localparam logic [OPCODE_W-1:0] LXOR = 4'h4;
  localparam logic [OPCODE_W-1:0] SHL  = 4'h5;
  localparam logic [OPCODE_W-1:0] SHR  = 4'h6;
  localparam logic [OPCODE_W-1:0] MOV  = 4'h7;
  localparam logic [OPCODE_W-1:0] LD   = 4'h8;
  localparam logic [OPCODE_W-1:0] ST   = 4'h9;
  localparam logic [OPCODE_W-1:0] JMP  = 4'hA;
  localparam logic [OPCODE_W-1:0] JZ   = 4'hB;
  localparam logic [OPCODE_W-1:0] JNZ  = 4'hC;
  localparam logic [OPCODE_W-1:0] CALL = 4'hD;
  localparam logic [OPCODE_W-1:0] RET  = 4'hE;
  localparam logic [OPCODE_W-1:0] LDI  = 4'hF;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: two big-endian byte reads per instruction over req/ack, presented on valid/ready.
// 3 cycles per instruction at zero wait; no memory request while inst_valid waits on inst_ready.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  output logic [INST_W-1:0]     inst,
  output logic [OPCODE_W-1:0]   opcode,
  output logic [ADDR_W-1:0]     inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_pc
);

  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] EVEN_MK = ~ONE;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_p1;
  logic [ADDR_W-1:0] pc_p2;
  logic [ADDR_W-1:0] target_pc;
  logic [7:0]        hi_byte;
  logic              discard;
  logic              ack;

  assign pc_p1     = pc + ONE;
  assign pc_p2     = pc + TWO;
  assign target_pc = redirect_pc & EVEN_MK;
  // an ack only counts against a request we are actually driving
  assign ack       = mem_req & mem_ack;
  assign opcode    = inst[OPCODE_MSB:OPCODE_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH_HI;
      pc         <= RESET_PC;
      discard    <= 1'b0;
      hi_byte    <= 8'h00;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        FETCH_HI, FETCH_LO: begin
          mem_req <= 1'b1;
          if (discard) begin
            // wrong-path byte still in flight: wait for it, then restart at the latest target
            if (redirect) pc <= target_pc;
            if (ack) begin
              discard  <= 1'b0;
              state    <= FETCH_HI;
              mem_addr <= redirect ? target_pc : pc;
            end
          end else if (redirect) begin
            pc <= target_pc;
            if (ack || !mem_req) begin
              state    <= FETCH_HI;
              mem_addr <= target_pc;
            end else begin
              discard <= 1'b1;
            end
          end else if (ack) begin
            if (state == FETCH_HI) begin
              hi_byte  <= mem_rdata;
              mem_addr <= pc_p1;
              state    <= FETCH_LO;
            end else begin
              inst       <= {hi_byte, mem_rdata};
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc_p2;
              mem_req    <= 1'b0;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc         <= target_pc;
            inst_valid <= 1'b0;
            mem_addr   <= target_pc;
            mem_req    <= 1'b1;
            state      <= FETCH_HI;
          end else if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
            mem_addr   <= pc;
            mem_req    <= 1'b1;
            state      <= FETCH_HI;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= FETCH_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a 16-bit-address instance with a wait-state memory model
// and an 8-bit-address instance on zero-wait memory for the wrap-around case.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;

  logic        mem_req, mem_ack, inst_valid, inst_ready, redirect;
  logic [15:0] mem_addr, inst_pc, redirect_pc, inst;
  logic [7:0]  mem_rdata;
  logic [3:0]  opcode;

  logic        mem_req8, mem_ack8, inst_valid8, inst_ready8, redirect8;
  logic [7:0]  mem_addr8, inst_pc8, redirect_pc8, mem_rdata8;
  logic [15:0] inst8;
  logic [3:0]  opcode8;

  logic [7:0]  mem  [0:255];
  logic [7:0]  mem8 [0:255];
  int          wait_cfg;
  int          cnt;

  int          n_chk;
  int          n_err;

  inst_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst(inst), .opcode(opcode), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  inst_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req8), .mem_addr(mem_addr8), .mem_ack(mem_ack8), .mem_rdata(mem_rdata8),
    .inst(inst8), .opcode(opcode8), .inst_pc(inst_pc8), .inst_valid(inst_valid8),
    .inst_ready(inst_ready8), .redirect(redirect8), .redirect_pc(redirect_pc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: ack after wait_cfg cycles of request; an abandoned request is forgotten on reset
  assign mem_ack   = mem_req && (cnt == wait_cfg);
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= 0;
    else if (mem_req && !mem_ack) cnt <= cnt + 1;
    else                        cnt <= 0;
  end

  assign mem_ack8   = mem_req8;
  assign mem_rdata8 = mem8[mem_addr8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    redirect  = 1'b0;
    redirect8 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!inst_valid && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_valid8(input string tag);
    int n;
    n = 0;
    while (!inst_valid8 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(inst_valid8), 32'd1);
  endtask

  logic [15:0] exp_inst [3];
  logic [15:0] exp_pc   [3];

  initial begin
    int n;
    logic seen;

    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i * 7 + 3);
      mem8[i] = 8'(i * 13 + 1);
    end
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'hC5;
    mem[3] = 8'h67; mem[4] = 8'hF0; mem[5] = 8'h0A;
    mem[8'h30] = 8'h9A; mem[8'h31] = 8'hBC;
    mem8[8'hFE] = 8'hDE; mem8[8'hFF] = 8'hAD;
    mem8[8'h00] = 8'h5E; mem8[8'h01] = 8'h11;
    exp_inst[0] = 16'h1234; exp_pc[0] = 16'h0000;
    exp_inst[1] = 16'hC567; exp_pc[1] = 16'h0002;
    exp_inst[2] = 16'hF00A; exp_pc[2] = 16'h0004;

    wait_cfg     = 0;
    inst_ready   = 1'b1;
    inst_ready8  = 1'b1;
    redirect_pc  = 16'h0000;
    redirect_pc8 = 8'h00;

    // reset values and zero-wait streaming
    do_reset();
    chk("rst mem_req",    32'(mem_req),    32'd0);
    chk("rst mem_addr",   32'(mem_addr),   32'h0000);
    chk("rst inst",       32'(inst),       32'h0000);
    chk("rst inst_pc",    32'(inst_pc),    32'h0000);
    chk("rst inst_valid", 32'(inst_valid), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      chk("stream valid",   32'(inst_valid), (c % 3 == 2) ? 32'd1 : 32'd0);
      chk("stream mem_req", 32'(mem_req),    (c % 3 == 2) ? 32'd0 : 32'd1);
      if (c == 0) chk("first mem_addr", 32'(mem_addr), 32'h0000);
      if (c % 3 == 2) begin
        chk("stream inst",    32'(inst),    32'(exp_inst[c/3]));
        chk("stream opcode",  32'(opcode),  32'(exp_inst[c/3] >> 12));
        chk("stream inst_pc", 32'(inst_pc), 32'(exp_pc[c/3]));
      end
    end

    // two wait states per byte
    do_reset();
    wait_cfg = 2;
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      if (c < 6) begin
        chk("wait mem_req",  32'(mem_req),    32'd1);
        chk("wait mem_addr", 32'(mem_addr),   (c < 3) ? 32'h0000 : 32'h0001);
        chk("wait valid",    32'(inst_valid), 32'd0);
      end else begin
        chk("wait late valid", 32'(inst_valid), 32'd1);
        chk("wait inst",       32'(inst),       32'h1234);
      end
    end

    // decode stall: hold output, no memory traffic, pc unchanged
    do_reset();
    wait_cfg   = 0;
    inst_ready = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      chk("stall valid",   32'(inst_valid), 32'd1);
      chk("stall inst",    32'(inst),       32'h1234);
      chk("stall opcode",  32'(opcode),     32'h1);
      chk("stall inst_pc", 32'(inst_pc),    32'h0000);
      chk("stall mem_req", 32'(mem_req),    32'd0);
      if (k < 4) step();
    end
    inst_ready = 1'b1;
    step();
    chk("unstall valid",    32'(inst_valid), 32'd0);
    chk("unstall mem_addr", 32'(mem_addr),   32'h0002);
    chk("unstall mem_req",  32'(mem_req),    32'd1);
    repeat (2) step();
    chk("unstall inst",    32'(inst),    32'hC567);
    chk("unstall inst_pc", 32'(inst_pc), 32'h0002);

    // redirect while the low-byte request is waiting
    do_reset();
    wait_cfg = 3;
    rst_n = 1'b1;
    n = 0;
    while (mem_addr != 16'h0001 && n < 20) begin
      step();
      n++;
    end
    chk("redir reach lo", 32'(mem_addr), 32'h0001);
    redirect    = 1'b1;
    redirect_pc = 16'h0031;
    step();
    redirect = 1'b0;
    chk("redir hold req",  32'(mem_req),  32'd1);
    chk("redir hold addr", 32'(mem_addr), 32'h0001);
    seen = 1'b0;
    n = 0;
    while (mem_addr == 16'h0001 && n < 20) begin
      step();
      n++;
      if (inst_valid) seen = 1'b1;
    end
    chk("redir no old valid", 32'(seen),     32'd0);
    chk("redir new addr",     32'(mem_addr), 32'h0030);
    chk("redir new req",      32'(mem_req),  32'd1);
    wait_cfg = 0;
    wait_valid("redir valid", n);
    chk("redir inst",    32'(inst),    32'h9ABC);
    chk("redir inst_pc", 32'(inst_pc), 32'h0030);
    chk("redir opcode",  32'(opcode),  32'h9);

    // 8-bit address space: wrap from 0xFF to 0x00
    do_reset();
    rst_n = 1'b1;
    repeat (4) step();
    redirect8    = 1'b1;
    redirect_pc8 = 8'hFE;
    step();
    redirect8 = 1'b0;
    wait_valid8("wrap valid FE");
    chk("wrap inst_pc FE", 32'(inst_pc8), 32'h00FE);
    chk("wrap inst FE",    32'(inst8),    32'hDEAD);
    step();
    wait_valid8("wrap valid 00");
    chk("wrap inst_pc 00", 32'(inst_pc8), 32'h0000);
    chk("wrap inst 00",    32'(inst8),    32'h5E11);

    // reset in the middle of a low-byte fetch
    do_reset();
    wait_cfg = 2;
    rst_n = 1'b1;
    repeat (4) step();
    chk("midrst pre req",  32'(mem_req),  32'd1);
    chk("midrst pre addr", 32'(mem_addr), 32'h0001);
    rst_n = 1'b0;
    #1;
    chk("midrst mem_req",  32'(mem_req),    32'd0);
    chk("midrst valid",    32'(inst_valid), 32'd0);
    chk("midrst mem_addr", 32'(mem_addr),   32'h0000);
    @(negedge clk);
    wait_cfg = 0;
    rst_n = 1'b1;
    wait_valid("midrst restart valid", n);
    chk("midrst latency", 32'(n),       32'd3);
    chk("midrst inst",    32'(inst),    32'h1234);
    chk("midrst inst_pc", 32'(inst_pc), 32'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch unit: produces the 16-bit instruction words whose opcode field feeds the instruction decode ROM.
- Reads two bytes per instruction from byte-wide instruction memory over a req/ack interface. Byte order is big-endian: high byte at pc, low byte at pc+1.
- Presents each instruction to decode over a valid/ready handshake.
- Accepts PC redirects from the jump/branch path (wpc/spc).

Parameters:
ADDR_W, 16, instruction memory byte-address width; pc wraps modulo 2^ADDR_W
RESET_PC, 0, pc loaded on reset; must be even

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  out  1  memory read request, held until mem_ack
mem_addr  out  ADDR_W  byte address; stable while mem_req=1
mem_ack  in  1  read complete; mem_rdata valid this cycle; may arrive in the same cycle as mem_req
mem_rdata  in  8  read byte
inst  out  16  assembled instruction {hi,lo}
opcode  out  4  inst[15:12], to the decode ROM
inst_pc  out  ADDR_W  address of inst's high byte
inst_valid  out  1  inst/opcode/inst_pc valid
inst_ready  in  1  decode accepts; transfer on valid&ready
redirect  in  1  single-cycle pulse: next instruction fetched from redirect_pc
redirect_pc  in  ADDR_W  target; bit 0 ignored (forced 0)

Behaviour:
- Reset values (async, while rst_n=0):
  - state=FETCH_HI, pc=RESET_PC, discard=0
  - mem_req=0, mem_addr=RESET_PC
  - inst=0, inst_pc=0, inst_valid=0
- All outputs are registered; opcode is a wire slice of the inst register.
- State FETCH_HI: mem_req=1, mem_addr=pc.
  - On mem_ack: hi_byte<=mem_rdata, mem_addr<=pc+1, go to FETCH_LO.
- State FETCH_LO: mem_req=1, mem_addr=pc+1.
  - On mem_ack: inst<={hi_byte,mem_rdata}, inst_pc<=pc, inst_valid<=1, pc<=pc+2, go to HOLD.
- State HOLD: mem_req=0; inst, inst_pc, opcode held stable.
  - On inst_valid&inst_ready: inst_valid<=0, mem_addr<=pc, go to FETCH_HI.
- Throughput: 3 cycles per instruction with zero-wait memory and inst_ready=1. inst_valid rises 2 cycles after the first mem_req cycle.
- Each memory wait cycle adds one cycle. mem_req/mem_addr never change before mem_ack.
- Arithmetic: pc+1 and pc+2 are modulo 2^ADDR_W. Address max-1 (odd) wraps the next fetch to 0.
- Redirect (has priority over every other pc update):
  - pc<=redirect_pc&~1.
  - In HOLD: inst_valid<=0 next cycle, go to FETCH_HI. If inst_ready was also 1 in that cycle, the transfer counts as completed.
  - In FETCH_HI/FETCH_LO with ack this cycle or no request outstanding: go to FETCH_HI at the new pc; the ack'd byte is dropped.
  - In FETCH_HI/FETCH_LO with a request outstanding and no ack: keep mem_req/mem_addr unchanged, set discard=1. On the eventual ack, drop the data, clear discard, go to FETCH_HI at the new pc. No instruction from the old path is ever presented.
  - A second redirect while discard=1 overwrites pc (last wins).
- inst_ready is ignored when inst_valid=0.
- Reset asserted mid-transaction drops mem_req immediately; the memory must tolerate an abandoned request.
- First mem_req rises in the first clock after rst_n deasserts.

Decomposition:
- Shared package cpu_pkg:
  - INST_W=16, OPCODE_W=4, OPCODE_MSB=15, OPCODE_LSB=12
  - fetch_state_t enum {FETCH_HI, FETCH_LO, HOLD}
  - opcode localparams (ADD=0 … LDI=F), shared with the decode ROM
- No sub-module; the block is one FSM plus pc/instruction registers.

Test Plan:
- Reset, zero-wait memory, mem[0..5]=12 34 C5 67 F0 0A, inst_ready=1 -> inst 0x1234 (opcode 1, inst_pc 0), then 0xC567 (C, 2), then 0xF00A (F, 4); inst_valid is a 1-cycle pulse every 3 cycles.
- 2 wait cycles on each byte -> mem_addr/mem_req stable during waits; inst 0x1234 arrives 4 cycles later than in the zero-wait case.
- inst_ready=0 for 5 cycles after first valid -> inst/opcode/inst_pc held, mem_req=0 throughout, and no pc advance.
- redirect to 0x0031 while the FETCH_LO request waits for ack -> old data dropped; next mem_addr=0x0030; next inst_pc=0x0030; no inst_valid for the old instruction.
- ADDR_W=8, redirect to 0xFE -> inst from 0xFE/0xFF, then fetch wraps to 0x00.
- rst_n low mid-FETCH_LO -> mem_req=0 and inst_valid=0 in the same cycle; after release, fetch restarts at RESET_PC.
